// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory bank: access-size codes, FSM states
// and the alignment check used to qualify every access.
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    // Illegal size codes count as misaligned so they share the same error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Byte-lane steering for one 32-bit word: merged store word (STORE=1) or
// extracted, sign/zero-extended load value (STORE=0).
module data_mem_lane
    import data_mem_pkg::*;
#(
    parameter bit STORE = 1'b0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wd,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [3:0]  mask;
    logic [31:0] lane_wd;
    logic [31:0] bit_mask;
    logic [31:0] merged;
    logic [31:0] loaded;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        mask    = 4'b1111;
        lane_wd = wd;
        case (size)
            SIZE_BYTE: begin
                mask    = 4'b0001 << offset;
                lane_wd = {4{wd[7:0]}};
            end
            SIZE_HALF: begin
                mask    = offset[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{wd[15:0]}};
            end
            default: ;
        endcase

        // Replicated write data lets the mask alone pick the destination lanes.
        bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        merged   = (word & ~bit_mask) | (lane_wd & bit_mask);

        sel_byte = word[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: loaded = uns ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: loaded = uns ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default:   loaded = word;
        endcase

        data = STORE ? merged : loaded;
    end

endmodule

// File: rtl/data_memory_bank.sv
// Multi-cycle data memory with req/ack handshake, programmable wait states,
// sub-word loads/stores and explicit alignment / range error reporting.
module data_memory_bank
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WE,
    input  logic [1:0]        SIZE,
    input  logic              UNS,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic              ACK,
    output logic              BUSY,
    output logic              ALIGN_ERR,
    output logic              RANGE_ERR
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]        CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              lat_we;
    logic              lat_uns;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_a;
    logic [31:0]       lat_wd;

    // Contents survive reset; only the power-up image is zero.
    logic [31:0]       mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]  idx;
    logic [31:0]       word;
    logic [31:0]       st_word;
    logic [31:0]       ld_word;
    logic              bad_align;
    logic              bad_range;

    assign idx       = lat_a[IDX_W+1:2];
    assign word      = mem[idx];
    assign bad_align = misaligned(lat_size, lat_a[1:0]);
    assign bad_range = !bad_align && (lat_a[ADDR_W-1:2] >= DEPTH_LIM);
    assign BUSY      = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (REQ) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (cnt == '0) state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= '0;
            lat_a     <= '0;
            lat_wd    <= '0;
            RD        <= '0;
            ACK       <= 1'b0;
            ALIGN_ERR <= 1'b0;
            RANGE_ERR <= 1'b0;
        end else begin
            ACK <= 1'b0;
            case (state)
                IDLE: if (REQ) begin
                    lat_we   <= WE;
                    lat_uns  <= UNS;
                    lat_size <= SIZE;
                    lat_a    <= A;
                    lat_wd   <= WD;
                    cnt      <= CNT_INIT;
                end
                WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                ACCESS: begin
                    ACK       <= 1'b1;
                    ALIGN_ERR <= bad_align;
                    RANGE_ERR <= bad_range;
                    RD        <= (!lat_we && !bad_align && !bad_range) ? ld_word : '0;
                end
                default: ;
            endcase
        end
    end

    // An async reset forces IDLE before this edge, so an aborted access never writes.
    always_ff @(posedge CLK) begin
        if (state == ACCESS && lat_we && !bad_align && !bad_range) mem[idx] <= st_word;
    end

    data_mem_lane #(.STORE(1'b1)) store_lane (
        .size   (lat_size),
        .offset (lat_a[1:0]),
        .uns    (lat_uns),
        .wd     (lat_wd),
        .word   (word),
        .data   (st_word)
    );

    data_mem_lane #(.STORE(1'b0)) load_lane (
        .size   (lat_size),
        .offset (lat_a[1:0]),
        .uns    (lat_uns),
        .wd     (lat_wd),
        .word   (word),
        .data   (ld_word)
    );

endmodule
